// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad responder replaying bounce/hold/release/gap per requested key
module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 1000,
  parameter int BOUNCE_TOGGLE = 100,
  parameter int HOLD_CYCLES   = 50000,
  parameter int GAP_CYCLES    = 50000,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_sweep,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] column_in,
  output logic       busy,
  output logic       press_done,
  output logic       contact
);

  typedef enum logic [2:0] {S_IDLE, S_PB, S_HOLD, S_RB, S_GAP} state_t;

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOGGLE_LAST = CNT_W'(BOUNCE_TOGGLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [3:0]       key_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tog;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      key_r      <= '0;
      cnt        <= '0;
      tog        <= '0;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      press_done <= 1'b0;
      contact    <= 1'b0;
    end else begin
      press_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_valid && key_ready) begin
            key_r     <= key_code;
            cnt       <= '0;
            tog       <= '0;
            state     <= S_PB;
            contact   <= 1'b1;
            busy      <= 1'b1;
            key_ready <= 1'b0;
          end else begin
            key_ready <= 1'b1;
          end
        end
        // Both bounce phases share the toggle logic; only the exit differs.
        S_PB, S_RB: begin
          if (cnt == BOUNCE_LAST) begin
            cnt <= '0;
            tog <= '0;
            if (state == S_PB) begin
              state   <= S_HOLD;
              contact <= 1'b1;
            end else begin
              state   <= S_GAP;
              contact <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (tog == TOGGLE_LAST) begin
              tog     <= '0;
              contact <= ~contact;
            end else begin
              tog <= tog + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            tog     <= '0;
            state   <= S_RB;
            contact <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt        <= '0;
            state      <= S_IDLE;
            busy       <= 1'b0;
            key_ready  <= 1'b1;
            press_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          contact   <= 1'b0;
          key_ready <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency column answer: only the latched key's row is observed.
  always_comb begin
    column_in = 4'b1111;
    if (contact && !row_sweep[key_r[3:2]])
      column_in[key_r[1:0]] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - randomized self-checking bench for keypad_emulator
module tb_keypad_emulator;

  localparam int B = 8;
  localparam int T = 2;
  localparam int H = 20;
  localparam int G = 10;
  localparam int SPAN = 2 * B + H + G;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_sweep = 4'b1111;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'b0000;
  logic       key_ready;
  logic [3:0] column_in;
  logic       busy;
  logic       press_done;
  logic       contact;

  int n_checks = 0;
  int n_fail = 0;

  keypad_emulator #(
    .BOUNCE_CYCLES(B), .BOUNCE_TOGGLE(T), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .row_sweep(row_sweep), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .column_in(column_in), .busy(busy), .press_done(press_done),
    .contact(contact)
  );

  always #5 clk = ~clk;

  // Contact level k cycles after the accept edge, from the phase-length rules.
  function automatic logic exp_contact(int k);
    int j;
    j = k - 1;
    if (k < 1) return 1'b0;
    if (j < B) return ((j / T) % 2) == 0;
    if (j < B + H) return 1'b1;
    if (j < 2 * B + H) return ((j - B - H) / T) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_col(logic c, logic [3:0] key, logic [3:0] rs);
    logic [3:0] v;
    v = 4'b1111;
    if (c && rs[key[3:2]] == 1'b0) v = ~(4'b0001 << key[1:0]);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b1; key_code = 4'b0110; row_sweep = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (column_in !== 4'b1111 || key_ready !== 1'b0 || busy !== 1'b0 || contact !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: col=%b rdy=%b busy=%b contact=%b, required col=1111 rdy=0 busy=0 contact=0",
                 i, column_in, key_ready, busy, contact);
      end
    end
    rst = 1'b0; key_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b busy=%b, required rdy=1 busy=0", key_ready, busy);
    end
  endtask

  // mode 0: fixed row, 1: wrong/no row, 2: rotating sweep in HOLD, 3: random sweep
  task automatic test_press(input logic [3:0] code, input int mode);
    logic [3:0] rs;
    @(negedge clk);
    key_valid = 1'b1; key_code = code; row_sweep = 4'b1111; #1;
    n_checks++;
    if (key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL press_ready mode%0d: rdy=%b, required 1", mode, key_ready);
    end
    for (int k = 1; k <= SPAN + 1; k++) begin
      @(negedge clk);
      key_valid = 1'b0; key_code = 4'($urandom);
      case (mode)
        0: rs = 4'b1101;
        1: rs = (k < 24) ? 4'b1110 : 4'b1111;
        2: rs = (k > B && k <= B + H) ? ~(4'b0001 << (k % 4)) : 4'b1111;
        default: rs = 4'($urandom);
      endcase
      row_sweep = rs; #1;
      n_checks++;
      if (contact !== exp_contact(k) || column_in !== exp_col(exp_contact(k), code, rs)) begin
        n_fail++;
        $display("FAIL press mode%0d k=%0d: contact=%b col=%b, required contact=%b col=%b",
                 mode, k, contact, column_in, exp_contact(k), exp_col(exp_contact(k), code, rs));
      end
      n_checks++;
      if (busy !== (k <= SPAN) || press_done !== (k == SPAN + 1) || key_ready !== (k == SPAN + 1)) begin
        n_fail++;
        $display("FAIL press_flags mode%0d k=%0d: busy=%b done=%b rdy=%b", mode, k, busy, press_done, key_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rs;
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'b0000; row_sweep = 4'b1111;
    for (int k = 1; k <= SPAN + 1; k++) begin
      @(negedge clk);
      key_code = (k >= 2) ? 4'b0101 : 4'b0000;
      rs = 4'($urandom); row_sweep = rs; #1;
      n_checks++;
      if (contact !== exp_contact(k) || column_in !== exp_col(exp_contact(k), 4'b0000, rs)) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d: contact=%b col=%b, required contact=%b col=%b",
                 k, contact, column_in, exp_contact(k), exp_col(exp_contact(k), 4'b0000, rs));
      end
    end
    n_checks++;
    if (press_done !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b rdy=%b, required 1 1", press_done, key_ready);
    end
    for (int k = 1; k <= SPAN + 1; k++) begin
      @(negedge clk);
      key_valid = 1'b0; key_code = 4'($urandom);
      rs = 4'($urandom); row_sweep = rs; #1;
      n_checks++;
      if (contact !== exp_contact(k) || column_in !== exp_col(exp_contact(k), 4'b0101, rs) ||
          busy !== (k <= SPAN) || press_done !== (k == SPAN + 1)) begin
        n_fail++;
        $display("FAIL b2b_second k=%0d: contact=%b col=%b busy=%b done=%b, required contact=%b col=%b",
                 k, contact, column_in, busy, press_done, exp_contact(k), exp_col(exp_contact(k), 4'b0101, rs));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'b1010; row_sweep = 4'b1011;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      key_valid = 1'b0; #1;
      n_checks++;
      if (contact !== exp_contact(k)) begin
        n_fail++;
        $display("FAIL rmh_pre k=%0d: contact=%b, required %b", k, contact, exp_contact(k));
      end
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (contact !== 1'b0 || column_in !== 4'b1111 || busy !== 1'b0 || press_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmh_reset: contact=%b col=%b busy=%b done=%b, required 0 1111 0 0",
               contact, column_in, busy, press_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (press_done !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rmh_idle i=%0d: done=%b busy=%b rdy=%b, required 0 0 1", i, press_done, busy, key_ready);
      end
    end
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; #1;
    n_checks++;
    if (contact !== 1'b1 || busy !== 1'b1 || column_in !== 4'b1011) begin
      n_fail++;
      $display("FAIL rmh_new_press: contact=%b busy=%b col=%b, required 1 1 1011", contact, busy, column_in);
    end
    for (int k = 2; k <= SPAN + 1; k++) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_press(4'b0110, 0);
    test_press(4'b0110, 1);
    test_press(4'b1111, 2);
    for (int i = 0; i < 4; i++) test_press(4'($urandom), 3);
    test_back_to_back();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
